data_c_head_body_split: RTL and testbench
=========================================

# data_c_head_body_split

Splits one framed input stream into a head stream and a body stream for the head/body/end merge stage. The first HEAD_NUM beats of each frame go to the head port, and the remaining beats go to the body port. Both outputs carry per-beat last flags, so the merge stage sees head_last on the final head beat and body_last on the final body beat. The block sits directly upstream of the merge stage's head and body slave ports.

## Interface
- DSIZE, 8: data width of all streams.
- HEAD_NUM, 4: head beats per frame; must be at least 1.
- PAD_DATA, '0: data value of the filler body beat (DSIZE bits).
- clock  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  DSIZE  input beat data.
- s_valid  in  1  input beat valid.
- s_last  in  1  last beat of the input frame.
- s_ready  out  1  input ready (combinational).
- head_data  out  DSIZE  head beat data (registered).
- head_valid  out  1  head beat valid.
- head_last  out  1  final head beat of the frame.
- head_ready  in  1  head consumer ready.
- body_data  out  DSIZE  body beat data (registered).
- body_valid  out  1  body beat valid.
- body_last  out  1  final body beat of the frame.
- body_ready  in  1  body consumer ready.
- runt_cnt  out  16  saturating count of frames with no body beats.

## Operation
- **Output slots.** Each output has one register slot made of data, valid and last.
  - A slot is free when its valid is 0, or when its valid is 1 and its ready is 1 in the same cycle.
- **Input ready.**
  - s_ready = (state==HEAD and head slot free) or (state==BODY and body slot free).
  - s_ready is 0 in PAD and while rst is high.
- **Beat counter.** cnt has width $clog2(HEAD_NUM+1) and counts head beats accepted in the current frame.
- **State HEAD** (reset state). On an accepted input beat, load the head slot with s_data, then:
  - If s_last: head_last=1, go to PAD, cnt=0.
  - Else if cnt==HEAD_NUM-1: head_last=1, go to BODY, cnt=0.
  - Otherwise: head_last=0, cnt+1.
- **State BODY.** On an accepted input beat, load the body slot with s_data and set body_last=s_last.
  - If s_last, go to HEAD.
- **State PAD** (runt frame; entered when the input frame has at most HEAD_NUM beats).
  - When the body slot is free, load it with PAD_DATA and body_last=1, then go to HEAD.
  - runt_cnt increments on entry to PAD and saturates at 16'hFFFF.
- **Simultaneous events.** A slot may drain and reload in the same cycle, giving full throughput of 1 beat per cycle.
  - The head and body slots operate independently, so a body beat may be loaded while the last head beat is still pending.
- **Ordering.** Beat order within each output is the input order. The downstream merge stage enforces head-before-body ordering.
- **Reset mid-frame.**
  - All slots are emptied and the partial frame is discarded with no last emitted.
  - cnt=0 and state=HEAD. runt_cnt clears.

## Timing
- Reset values:
  - head_valid, body_valid, head_last and body_last are 0.
  - head_data and body_data are 0.
  - runt_cnt is 0; state is HEAD; cnt is 0.
- Latency: an input beat accepted at edge N is valid on its output after edge N.
- The pad beat is valid one cycle after the runt frame's last beat is accepted if the body slot is free; otherwise it is valid on the cycle after the slot frees.
- During PAD, s_ready=0 for at least 1 cycle, so each runt frame costs one bubble.
- Valid and data are held stable until ready (standard valid/ready rule): head_valid, head_data and head_last do not change while head_valid=1 and head_ready=0; body_valid, body_data and body_last do not change while body_valid=1 and body_ready=0.

## Configuration
- The macro DATA_C_HEAD_BODY_SPLIT_RUNT_PAD_EN controls runt-frame handling.
- Defined:
  - PAD state is present; runt frames get one PAD_DATA body beat with body_last=1.
  - runt_cnt is active.
- Undefined:
  - No PAD state; a runt frame returns straight to HEAD after the head beat carrying head_last, and no body beat is emitted.
  - runt_cnt is tied to 0.

## Test plan
- **Normal frame.** HEAD_NUM=4, 6-beat frame 0x10..0x15, ready always 1.
  - Head gets 0x10..0x13 with head_last on 0x13; body gets 0x14,0x15 with body_last on 0x15.
  - No bubbles; runt_cnt=0.
- **Exact-length frame.** 4-beat frame 0x20..0x23 with the macro defined.
  - head_last is set on 0x23; body gets one beat of PAD_DATA with body_last=1; runt_cnt=1.
  - Repeat with the macro undefined: no body beat is emitted and runt_cnt stays 0.
- **Short runt frame.** 2-beat frame 0x30,0x31 followed immediately by the 5-beat frame 0x40..0x44.
  - head_last is set on 0x31, then the pad beat is emitted.
  - Head then gets 0x40..0x43; body gets 0x44 with body_last.
  - s_ready=0 for exactly one cycle.
- **Backpressure.** body_ready is held 0 for 5 cycles during a 10-beat frame.
  - body_valid, body_data and body_last are held stable; s_ready drops while the body slot is full.
  - No beat is lost or duplicated.
- **Reset mid-frame.** Assert rst asynchronously after 2 beats of a frame.
  - All valids drop immediately; no last is emitted.
  - The next frame starts in HEAD with cnt=0.
- **Back-to-back traffic.** 100 frames of random length 1..12 with random ready.
  - Concatenating head and body beats reproduces the input stream exactly, plus one pad beat per frame of at most 4 beats.
  - runt_cnt equals the number of such frames.

Source files
------------

// File: rtl/data_c_head_body_split.sv
// data_c_head_body_split: routes the first HEAD_NUM beats of each frame to the
// head port and the remaining beats to the body port, each with its own last flag.
// Optional runt-frame padding is enabled by DATA_C_HEAD_BODY_SPLIT_RUNT_PAD_EN:
// a frame of at most HEAD_NUM beats then gets one PAD_DATA body beat and is
// counted in runt_cnt; without the macro runt frames emit no body beat.
module data_c_head_body_split #(
    parameter int unsigned             DSIZE    = 8,
    parameter int unsigned             HEAD_NUM = 4,
    parameter logic [DSIZE-1:0]        PAD_DATA = '0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [DSIZE-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [DSIZE-1:0] head_data,
    output logic             head_valid,
    output logic             head_last,
    input  logic             head_ready,
    output logic [DSIZE-1:0] body_data,
    output logic             body_valid,
    output logic             body_last,
    input  logic             body_ready,
    output logic [15:0]      runt_cnt
);

    localparam int unsigned CW = $clog2(HEAD_NUM + 1);

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_BODY = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DSIZE-1:0] head_data_q, head_data_d;
    logic             head_valid_q, head_valid_d;
    logic             head_last_q, head_last_d;
    logic [DSIZE-1:0] body_data_q, body_data_d;
    logic             body_valid_q, body_valid_d;
    logic             body_last_q, body_last_d;

    logic             head_free_c;
    logic             body_free_c;
    logic             accept_c;

    // A slot can take a new beat when empty or draining this cycle
    assign head_free_c = !head_valid_q || head_ready;
    assign body_free_c = !body_valid_q || body_ready;
    assign s_ready     = !rst && (((state_q == ST_HEAD) && head_free_c) ||
                                  ((state_q == ST_BODY) && body_free_c));
    assign accept_c    = s_valid && s_ready;

`ifdef DATA_C_HEAD_BODY_SPLIT_RUNT_PAD_EN
    logic [15:0] runt_q, runt_d;
`endif

    // Next-state: slot drain, head/body steering, runt padding
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        head_data_d  = head_data_q;
        head_valid_d = head_valid_q;
        head_last_d  = head_last_q;
        body_data_d  = body_data_q;
        body_valid_d = body_valid_q;
        body_last_d  = body_last_q;
`ifdef DATA_C_HEAD_BODY_SPLIT_RUNT_PAD_EN
        runt_d       = runt_q;
`endif
        if (head_valid_q && head_ready) head_valid_d = 1'b0;
        if (body_valid_q && body_ready) body_valid_d = 1'b0;

        case (state_q)
            ST_HEAD: begin
                if (accept_c) begin
                    head_data_d  = s_data;
                    head_valid_d = 1'b1;
                    if (s_last) begin
                        head_last_d = 1'b1;
                        cnt_d       = '0;
`ifdef DATA_C_HEAD_BODY_SPLIT_RUNT_PAD_EN
                        state_d     = ST_PAD;
                        if (runt_q != 16'hFFFF) runt_d = runt_q + 16'd1;
`else
                        state_d     = ST_HEAD;
`endif
                    end else if (cnt_q == CW'(HEAD_NUM - 1)) begin
                        head_last_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_BODY;
                    end else begin
                        head_last_d = 1'b0;
                        cnt_d       = cnt_q + CW'(1);
                    end
                end
            end
            ST_BODY: begin
                if (accept_c) begin
                    body_data_d  = s_data;
                    body_valid_d = 1'b1;
                    body_last_d  = s_last;
                    if (s_last) state_d = ST_HEAD;
                end
            end
`ifdef DATA_C_HEAD_BODY_SPLIT_RUNT_PAD_EN
            ST_PAD: begin
                if (body_free_c) begin
                    body_data_d  = PAD_DATA;
                    body_valid_d = 1'b1;
                    body_last_d  = 1'b1;
                    state_d      = ST_HEAD;
                end
            end
`endif
            default: state_d = ST_HEAD;
        endcase
    end

    // State and output slot registers; reset discards any partial frame
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HEAD;
            cnt_q        <= '0;
            head_data_q  <= '0;
            head_valid_q <= 1'b0;
            head_last_q  <= 1'b0;
            body_data_q  <= '0;
            body_valid_q <= 1'b0;
            body_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            head_data_q  <= head_data_d;
            head_valid_q <= head_valid_d;
            head_last_q  <= head_last_d;
            body_data_q  <= body_data_d;
            body_valid_q <= body_valid_d;
            body_last_q  <= body_last_d;
        end
    end

`ifdef DATA_C_HEAD_BODY_SPLIT_RUNT_PAD_EN
    // Saturating runt-frame counter
    always_ff @(posedge clock or posedge rst) begin
        if (rst) runt_q <= '0;
        else     runt_q <= runt_d;
    end
    assign runt_cnt = runt_q;
`else
    assign runt_cnt = '0;
`endif

    assign head_data  = head_data_q;
    assign head_valid = head_valid_q;
    assign head_last  = head_last_q;
    assign body_data  = body_data_q;
    assign body_valid = body_valid_q;
    assign body_last  = body_last_q;

endmodule

// File: tb/tb_data_c_head_body_split.sv
// Directed bench for data_c_head_body_split (HEAD_NUM=4, DSIZE=8, PAD_DATA=0).
// Expectations follow DATA_C_HEAD_BODY_SPLIT_RUNT_PAD_EN when it is defined.
module tb_data_c_head_body_split;

    localparam int HN = 4;
`ifdef DATA_C_HEAD_BODY_SPLIT_RUNT_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  head_data;
    logic        head_valid;
    logic        head_last;
    logic        head_ready = 1'b1;
    logic [7:0]  body_data;
    logic        body_valid;
    logic        body_last;
    logic        body_ready = 1'b1;
    logic [15:0] runt_cnt;

    data_c_head_body_split #(.DSIZE(8), .HEAD_NUM(HN), .PAD_DATA(8'h00)) dut (
        .clock(clock), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .head_data(head_data), .head_valid(head_valid), .head_last(head_last),
        .head_ready(head_ready),
        .body_data(body_data), .body_valid(body_valid), .body_last(body_last),
        .body_ready(body_ready),
        .runt_cnt(runt_cnt)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail = 0;
    int exp_runt = 0;
    int hp = 0;
    int bp = 0;
    int stall_total = 0;
    int stab_err = 0;
    logic [8:0] got_head[$];
    logic [8:0] got_body[$];
    logic [8:0] exp_head[$];
    logic [8:0] exp_body[$];

    bit rand_ready = 1'b0;
    logic hr_f = 1'b1;
    logic br_f = 1'b1;

    // Ready drivers: forced values or random backpressure
    always @(posedge clock) begin
        #1;
        if (rand_ready) begin
            head_ready = ($urandom_range(0, 3) != 0);
            body_ready = ($urandom_range(0, 3) != 0);
        end else begin
            head_ready = hr_f;
            body_ready = br_f;
        end
    end

    // Monitor: collect transfers, input stalls and hold-while-stalled violations
    logic       h_stuck = 1'b0;
    logic       b_stuck = 1'b0;
    logic [8:0] h_prev = '0;
    logic [8:0] b_prev = '0;
    always @(negedge clock) begin
        if (rst) begin
            h_stuck <= 1'b0;
            b_stuck <= 1'b0;
        end else begin
            if ((h_stuck && !(head_valid && ({head_last, head_data} == h_prev))) ||
                (b_stuck && !(body_valid && ({body_last, body_data} == b_prev))))
                stab_err <= stab_err + 1;
            if (head_valid && head_ready) got_head.push_back({head_last, head_data});
            if (body_valid && body_ready) got_body.push_back({body_last, body_data});
            if (s_valid && !s_ready) stall_total <= stall_total + 1;
            h_stuck <= head_valid && !head_ready;
            b_stuck <= body_valid && !body_ready;
            h_prev  <= {head_last, head_data};
            b_prev  <= {body_last, body_data};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        bit took = 1'b0;
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!took && guard < 200) begin
            @(negedge clock);
            took = s_ready;
            @(posedge clock);
            #1;
            guard++;
        end
        if (!took) check("accept_timeout", 32'(took), 1);
    endtask

    task automatic send_frame(input int len, input logic [7:0] base);
        int nh;
        logic [7:0] d;
        nh = (len < HN) ? len : HN;
        for (int i = 0; i < len; i++) begin
            d = base + 8'(i);
            if (i < nh) exp_head.push_back({(i == nh - 1), d});
            else        exp_body.push_back({(i == len - 1), d});
        end
        if (len <= HN && PAD_EN) begin
            exp_body.push_back({1'b1, 8'h00});
            exp_runt++;
        end
        for (int i = 0; i < len; i++) send_beat(base + 8'(i), (i == len - 1));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        int g = 0;
        while (!idle && g < 100) begin
            cycle();
            idle = !head_valid && !body_valid && s_ready;
            g++;
        end
        check("idle_timeout", 32'(idle), 1);
    endtask

    task automatic compare_streams(input string tag);
        check({tag, "_head_count"}, got_head.size() - hp, exp_head.size());
        for (int i = 0; i < exp_head.size(); i++)
            if (hp + i < got_head.size())
                check({tag, "_head_beat"}, 32'(got_head[hp + i]), 32'(exp_head[i]));
        check({tag, "_body_count"}, got_body.size() - bp, exp_body.size());
        for (int i = 0; i < exp_body.size(); i++)
            if (bp + i < got_body.size())
                check({tag, "_body_beat"}, 32'(got_body[bp + i]), 32'(exp_body[i]));
        hp = got_head.size();
        bp = got_body.size();
        exp_head.delete();
        exp_body.delete();
    endtask

    initial begin
        int s0;
        int e0;

        // Reset state
        repeat (2) cycle();
        check("rst_head_valid", 32'(head_valid), 0);
        check("rst_body_valid", 32'(body_valid), 0);
        check("rst_head_last", 32'(head_last), 0);
        check("rst_body_last", 32'(body_last), 0);
        check("rst_head_data", 32'(head_data), 0);
        check("rst_body_data", 32'(body_data), 0);
        check("rst_runt_cnt", 32'(runt_cnt), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 32'(s_ready), 1);
        cycle();

        // Normal 6-beat frame
        s0 = stall_total;
        send_frame(6, 8'h10);
        check("norm_body_valid", 32'(body_valid), 1);
        check("norm_body_data", 32'(body_data), 32'h15);
        check("norm_body_last", 32'(body_last), 1);
        check("norm_head_valid", 32'(head_valid), 0);
        check("norm_stalls", stall_total - s0, 0);
        wait_idle();
        compare_streams("norm");
        check("norm_runt_cnt", 32'(runt_cnt), exp_runt);

        // Exact-length frame
        send_frame(4, 8'h20);
        check("exact_head_data", 32'(head_data), 32'h23);
        check("exact_head_last", 32'(head_last), 1);
        check("exact_s_ready", 32'(s_ready), 32'(!PAD_EN));
        cycle();
        check("exact_body_valid", 32'(body_valid), 32'(PAD_EN));
`ifdef DATA_C_HEAD_BODY_SPLIT_RUNT_PAD_EN
        check("exact_pad_data", 32'(body_data), 0);
        check("exact_pad_last", 32'(body_last), 1);
`endif
        wait_idle();
        compare_streams("exact");
        check("exact_runt_cnt", 32'(runt_cnt), exp_runt);

        // Short runt frame followed back-to-back by a 5-beat frame
        s0 = stall_total;
        send_frame(2, 8'h30);
        send_frame(5, 8'h40);
        wait_idle();
        check("runt_stalls", stall_total - s0, 32'(PAD_EN));
        compare_streams("runt");
        check("runt_runt_cnt", 32'(runt_cnt), exp_runt);

        // Body backpressure during a 10-beat frame
        s0 = stall_total;
        e0 = stab_err;
        fork
            send_frame(10, 8'h50);
            begin
                repeat (6) cycle();
                br_f = 1'b0;
                repeat (5) cycle();
                br_f = 1'b1;
            end
        join
        wait_idle();
        check("bp_s_ready_dropped", 32'(stall_total - s0 > 0), 1);
        check("bp_hold_stable", stab_err - e0, 0);
        compare_streams("bp");

        // Asynchronous reset after two beats of a frame
        send_beat(8'h60, 1'b0);
        send_beat(8'h61, 1'b0);
        check("mid_head_valid_pre", 32'(head_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_head_valid", 32'(head_valid), 0);
        check("mid_body_valid", 32'(body_valid), 0);
        check("mid_head_last", 32'(head_last), 0);
        check("mid_runt_cnt", 32'(runt_cnt), 0);
        check("mid_s_ready", 32'(s_ready), 0);
        s_valid = 1'b0;
        exp_runt = 0;
        #3;
        rst = 1'b0;
        hp = got_head.size();
        bp = got_body.size();
        exp_head.delete();
        exp_body.delete();
        cycle();
        send_frame(6, 8'h70);
        wait_idle();
        compare_streams("after_rst");
        check("after_rst_runt_cnt", 32'(runt_cnt), exp_runt);

        // Back-to-back random frames with random ready
        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++)
            send_frame($urandom_range(1, 12), 8'($urandom));
        rand_ready = 1'b0;
        hr_f = 1'b1;
        br_f = 1'b1;
        wait_idle();
        compare_streams("rand");
        check("rand_runt_cnt", 32'(runt_cnt), exp_runt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
